// File: rtl/calc_pkg.sv
// Shared definitions for the calculator controller: key codes, ALU op encoding,
// controller states and limits.
package calc_pkg;
  localparam int          MAX_DIGITS = 4;
  localparam logic [15:0] MAX_VAL    = 16'd9999;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  typedef enum logic [2:0] {S_A, S_B, S_EXEC, S_RES, S_ERR} state_t;

  // Operator keys A..D map onto op encodings 0..3 in order.
  function automatic op_t key_to_op(input logic [3:0] k);
    logic [3:0] d;
    d = k - KEY_ADD;
    return op_t'(d[1:0]);
  endfunction
endpackage

// File: rtl/calc_ctrl_if.sv
// Start/done handshake between the calculator controller and the shared ALU.
interface calc_ctrl_if;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_abort;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;

  modport master (output alu_start, alu_op, alu_a, alu_b, alu_abort,
                  input  alu_done, alu_result, alu_err);
  modport slave  (input  alu_start, alu_op, alu_a, alu_b, alu_abort,
                  output alu_done, alu_result, alu_err);
endinterface

// File: rtl/bcd_entry.sv
// Decimal digit accumulator keeping binary value, packed BCD and digit count
// in step. restart treats the current operand as empty before taking the digit.
module bcd_entry
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        restart,
  input  logic        dig_vld,
  input  logic [3:0]  digit,
  output logic [15:0] value,
  output logic [15:0] bcd,
  output logic [2:0]  count
);
  logic [15:0] base_val;
  logic [15:0] base_bcd;
  logic [2:0]  base_cnt;

  always_comb begin
    base_val = restart ? 16'd0 : value;
    base_bcd = restart ? 16'd0 : bcd;
    base_cnt = restart ? 3'd0  : count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      bcd   <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      bcd   <= '0;
      count <= '0;
    end else if (dig_vld && base_cnt < 3'(MAX_DIGITS)) begin
      // x*10 as (x<<3)+(x<<1); base_val <= 999 here so 16 bits never overflow
      value <= (base_val << 3) + (base_val << 1) + {12'd0, digit};
      bcd   <= {base_bcd[11:0], digit};
      count <= base_cnt + 3'd1;
    end
  end
endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencing controller: keyed operand entry, ALU launch/abort,
// chained operations, repeat-equals and error lockout.
module calc_ctrl
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  calc_ctrl_if.master alu,
  output logic [15:0] disp_entry,
  output logic [15:0] disp_value,
  output logic        err
);
  state_t      state;
  logic [15:0] a_val, last_b;
  op_t         op, pend_op;
  logic        pend_vld;
  logic        start_q, abort_q;
  op_t         alu_op_q;
  logic [15:0] alu_a_q, alu_b_q;

  logic        is_digit, is_op, is_eq, is_clr;
  logic        done_ok, done_bad;
  logic        ent_clr, ent_restart, ent_dig;
  logic [15:0] ent_val, ent_bcd;
  logic [2:0]  ent_cnt;
  logic        go;
  logic [15:0] go_a, go_b;

  assign is_digit = key_valid && key_code <= 4'd9;
  assign is_op    = key_valid && key_code >= KEY_ADD && key_code <= KEY_DIV;
  assign is_eq    = key_valid && key_code == KEY_EQ;
  assign is_clr   = key_valid && key_code == KEY_CLR;
  assign done_ok  = alu.alu_done && !alu.alu_err && alu.alu_result <= MAX_VAL;
  assign done_bad = alu.alu_done && !done_ok;

  bcd_entry u_entry (
    .clk     (clk),
    .rst     (rst),
    .clr     (ent_clr),
    .restart (ent_restart),
    .dig_vld (ent_dig),
    .digit   (key_code),
    .value   (ent_val),
    .bcd     (ent_bcd),
    .count   (ent_cnt)
  );

  // Entry-module control and ALU launch decision for this cycle's key.
  always_comb begin
    ent_clr     = 1'b0;
    ent_restart = 1'b0;
    ent_dig     = 1'b0;
    go          = 1'b0;
    go_a        = a_val;
    go_b        = ent_val;
    if (is_clr) ent_clr = 1'b1;
    else begin
      case (state)
        S_A: begin
          ent_dig = is_digit;
          ent_clr = is_op;
        end
        S_B: begin
          ent_dig = is_digit;
          go      = (is_op || is_eq) && ent_cnt != 3'd0;
        end
        S_EXEC: ent_clr = done_ok && pend_vld;
        S_RES: begin
          ent_dig     = is_digit;
          ent_restart = is_digit;
          ent_clr     = is_op;
          go          = is_eq;
          go_a        = disp_value;
          go_b        = last_b;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_A;
      a_val      <= '0;
      last_b     <= '0;
      op         <= OP_ADD;
      pend_op    <= OP_ADD;
      pend_vld   <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      alu_op_q   <= OP_ADD;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      disp_value <= '0;
      err        <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      if (is_clr) begin
        state      <= S_A;
        a_val      <= '0;
        last_b     <= '0;
        op         <= OP_ADD;
        pend_op    <= OP_ADD;
        pend_vld   <= 1'b0;
        disp_value <= '0;
        err        <= 1'b0;
        // a coincident done means the ALU is already idle
        abort_q    <= (state == S_EXEC) && !alu.alu_done;
      end else if (go) begin
        state    <= S_EXEC;
        start_q  <= 1'b1;
        alu_a_q  <= go_a;
        alu_b_q  <= go_b;
        alu_op_q <= op;
        last_b   <= go_b;
        if (state == S_B && is_op) begin
          pend_op  <= key_to_op(key_code);
          pend_vld <= 1'b1;
        end
      end else begin
        case (state)
          S_A: if (is_op) begin
            a_val <= ent_val;
            op    <= key_to_op(key_code);
            state <= S_B;
          end
          S_B: if (is_op) op <= key_to_op(key_code);
          S_EXEC: begin
            if (done_bad) begin
              state    <= S_ERR;
              err      <= 1'b1;
              pend_vld <= 1'b0;
            end else if (done_ok) begin
              disp_value <= alu.alu_result;
              pend_vld   <= 1'b0;
              if (pend_vld) begin
                a_val <= alu.alu_result;
                op    <= pend_op;
                state <= S_B;
              end else begin
                state <= S_RES;
              end
            end
          end
          S_RES: begin
            if (is_digit) state <= S_A;
            else if (is_op) begin
              a_val <= disp_value;
              op    <= key_to_op(key_code);
              state <= S_B;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign alu.alu_start = start_q;
  assign alu.alu_abort = abort_q;
  assign alu.alu_op    = alu_op_q;
  assign alu.alu_a     = alu_a_q;
  assign alu.alu_b     = alu_b_q;
  assign disp_entry    = ent_bcd;
endmodule

// File: tb/tb_calc_ctrl.sv
// Directed key sequences against calc_ctrl with a behavioural multi-cycle ALU
// that never honours abort, so late completions reach the controller.
module tb_calc_ctrl;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [15:0] disp_entry, disp_value;
  logic        err;

  calc_ctrl_if alu_if ();

  calc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu        (alu_if),
    .disp_entry (disp_entry),
    .disp_value (disp_value),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_start = 0, n_done = 0, n_abort = 0;
  int lat = 5;
  int busy = 0, cnt = 0;
  int ra, rb, rop, rr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  // Behavioural ALU, driven on the falling edge.
  always @(negedge clk) begin
    alu_if.alu_done = 1'b0;
    alu_if.alu_err  = 1'b0;
    if (alu_if.alu_abort) n_abort++;
    if (alu_if.alu_start) begin
      n_start++;
      busy = 1;
      cnt  = lat;
      ra   = int'(alu_if.alu_a);
      rb   = int'(alu_if.alu_b);
      rop  = int'(alu_if.alu_op);
    end else if (busy != 0) begin
      cnt--;
      if (cnt == 0) begin
        busy = 0;
        alu_if.alu_err = 1'b0;
        case (rop)
          0: rr = ra + rb;
          1: begin rr = ra - rb; if (ra < rb) alu_if.alu_err = 1'b1; end
          2: rr = ra * rb;
          default: begin rr = (rb == 0) ? 0 : ra / rb; if (rb == 0) alu_if.alu_err = 1'b1; end
        endcase
        if (rr > 65535) alu_if.alu_err = 1'b1;
        alu_if.alu_result = rr[15:0];
        alu_if.alu_done   = 1'b1;
        n_done++;
      end
    end
  end

  task automatic press(input logic [3:0] c);
    @(negedge clk); #1;
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
  endtask

  task automatic wait_done(input string tag);
    int n0;
    n0 = n_done;
    for (int i = 0; i < 200 && n_done == n0; i++) begin @(negedge clk); #1; end
    chk(tag, 32'(n_done != n0), 32'd1);
    idle(2);
  endtask

  int s0, a0;

  initial begin
    alu_if.alu_result = '0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_state", 32'(dut.state), 32'(S_A));
    chk("rst_start", 32'(alu_if.alu_start), 0);
    chk("rst_abort", 32'(alu_if.alu_abort), 0);
    chk("rst_op", 32'(alu_if.alu_op), 0);
    chk("rst_a", 32'(alu_if.alu_a), 0);
    chk("rst_b", 32'(alu_if.alu_b), 0);
    chk("rst_entry", 32'(disp_entry), 0);
    chk("rst_value", 32'(disp_value), 0);
    chk("rst_err", 32'(err), 0);

    // 12 + 34 =
    lat = 5;
    s0 = n_start;
    press(4'd1); press(4'd2);
    chk("add_entry_a", 32'(disp_entry), 32'h0012);
    press(KEY_ADD);
    chk("add_entry_clr", 32'(disp_entry), 0);
    press(4'd3); press(4'd4);
    chk("add_entry_b", 32'(disp_entry), 32'h0034);
    press(KEY_EQ);
    chk("add_start", 32'(alu_if.alu_start), 1);
    wait_done("add_done");
    chk("add_nstart", 32'(n_start - s0), 1);
    chk("add_a", 32'(alu_if.alu_a), 12);
    chk("add_b", 32'(alu_if.alu_b), 34);
    chk("add_op", 32'(alu_if.alu_op), 0);
    chk("add_val", 32'(disp_value), 46);
    chk("add_state", 32'(dut.state), 32'(S_RES));

    // 5 * 4 - 3 = , then repeat-equals, then + 1 = from result
    press(KEY_CLR);
    lat = 3;
    press(4'd5); press(KEY_MUL); press(4'd4); press(KEY_SUB);
    chk("ch1_a", 32'(alu_if.alu_a), 5);
    chk("ch1_b", 32'(alu_if.alu_b), 4);
    chk("ch1_op", 32'(alu_if.alu_op), 2);
    wait_done("ch1_done");
    chk("ch1_state", 32'(dut.state), 32'(S_B));
    chk("ch1_val", 32'(disp_value), 20);
    chk("ch1_entry", 32'(disp_entry), 0);
    press(4'd3); press(KEY_EQ);
    wait_done("ch2_done");
    chk("ch2_a", 32'(alu_if.alu_a), 20);
    chk("ch2_b", 32'(alu_if.alu_b), 3);
    chk("ch2_op", 32'(alu_if.alu_op), 1);
    chk("ch2_val", 32'(disp_value), 17);
    chk("ch2_state", 32'(dut.state), 32'(S_RES));
    press(KEY_EQ);
    wait_done("rep_done");
    chk("rep_a", 32'(alu_if.alu_a), 17);
    chk("rep_val", 32'(disp_value), 14);
    press(KEY_ADD); press(4'd1); press(KEY_EQ);
    wait_done("res_op_done");
    chk("res_op_val", 32'(disp_value), 15);

    // 7 / 0 = -> error lockout
    press(KEY_CLR);
    press(4'd7); press(KEY_DIV); press(4'd0); press(KEY_EQ);
    wait_done("div0_done");
    chk("div0_err", 32'(err), 1);
    chk("div0_state", 32'(dut.state), 32'(S_ERR));
    press(4'd5);
    chk("div0_lock", 32'(dut.state), 32'(S_ERR));
    press(KEY_CLR);
    chk("div0_clr_state", 32'(dut.state), 32'(S_A));
    chk("div0_clr_err", 32'(err), 0);

    // 99999 -> fifth digit ignored; 9999 * 2 overflows the display range
    for (int i = 0; i < 5; i++) press(4'd9);
    chk("max_entry", 32'(disp_entry), 32'h9999);
    press(KEY_MUL); press(4'd2); press(KEY_EQ);
    chk("ovf_a", 32'(alu_if.alu_a), 9999);
    chk("ovf_b", 32'(alu_if.alu_b), 2);
    wait_done("ovf_done");
    chk("ovf_state", 32'(dut.state), 32'(S_ERR));
    chk("ovf_err", 32'(err), 1);

    // clear mid-operation -> abort, late done ignored
    press(KEY_CLR);
    lat = 10;
    press(4'd3); press(KEY_ADD); press(4'd4); press(KEY_EQ);
    s0 = n_start;
    a0 = n_abort;
    idle(1);
    press(KEY_CLR);
    chk("abort_pulse", 32'(n_abort - a0), 1);
    chk("abort_state", 32'(dut.state), 32'(S_A));
    wait_done("abort_late_done");
    chk("abort_val", 32'(disp_value), 0);
    chk("abort_state2", 32'(dut.state), 32'(S_A));
    chk("abort_nstart", 32'(n_start - s0), 0);

    // clear coincident with done -> no abort, result dropped
    lat = 4;
    press(4'd3); press(KEY_ADD); press(4'd4); press(KEY_EQ);
    a0 = n_abort;
    for (int i = 0; i < 50 && !alu_if.alu_done; i++) begin @(negedge clk); #1; end
    chk("co_done_seen", 32'(alu_if.alu_done), 1);
    key_valid = 1'b1;
    key_code  = KEY_CLR;
    @(negedge clk); #1;
    key_valid = 1'b0;
    idle(2);
    chk("co_abort", 32'(n_abort - a0), 0);
    chk("co_state", 32'(dut.state), 32'(S_A));
    chk("co_val", 32'(disp_value), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the four-digit calculator datapath. It takes one-cycle key events from the keypad scanner and accumulates operands in decimal. It drives a shared multi-cycle ALU through a start/done handshake and presents the entry and result values to the seven-segment display driver. It owns all calculator state, including chained operations, repeat-equals and error lockout.

## Interface
- MAX_DIGITS, 4: maximum decimal digits per operand.
- MAX_VAL, 9999: largest displayable result; anything above it is an error.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- key_valid  in  1  one-cycle key event strobe.
- key_code  in  4  key codes:
  - 0–9: digit.
  - A: add. B: subtract. C: multiply. D: divide.
  - E: equals. F: clear.
- alu_start  out  1  one-cycle pulse that launches the ALU.
- alu_op  out  2  operation: 0 add, 1 sub, 2 mul, 3 div.
- alu_a, alu_b  out  16  binary operands; held stable from alu_start until alu_done or abort.
- alu_abort  out  1  one-cycle pulse that cancels an in-flight ALU operation.
- alu_done  in  1  one-cycle completion pulse.
- alu_result  in  16  result, valid with alu_done.
- alu_err  in  1  divide-by-zero or overflow, valid with alu_done.
- disp_entry  out  16  packed BCD (4 nibbles) of the operand currently being keyed.
- disp_value  out  16  binary value to display (0..MAX_VAL).
- err  out  1  high while the controller is in S_ERR.

## Operation
States:
- **S_A** (entering the first operand). Reset and clear land here.
- **S_B** (entering the second operand).
- **S_EXEC** (ALU busy).
- **S_RES** (result shown).
- **S_ERR** (error lockout).

Digit entry (S_A, S_B):
- A digit updates the operand as val = val*10 + d, and shifts d into the BCD entry register from the low nibble.
- Digits beyond MAX_DIGITS are ignored.
- A leading zero counts as a digit.

S_A:
- Digit: accumulate into A.
- Operator: latch the op, clear the entry and digit count, go to S_B.
- Equals: ignored.

S_B:
- Digit: accumulate into B.
- Operator with no B digits yet: replaces the latched op.
- Operator with B digits entered: go to S_EXEC, recording the new op as pending (chained operation).
- Equals with no B digits: ignored.
- Equals with B digits: go to S_EXEC.

S_EXEC:
- Keys other than clear are ignored.
- On alu_done with alu_err=1, or with alu_result > MAX_VAL: go to S_ERR.
- On a successful alu_done with a pending op: A = result, op = pending, clear the entry, go to S_B. disp_value shows the result.
- On a successful alu_done with no pending op: disp_value = result, go to S_RES.

S_RES:
- Digit: start a new A with that digit, go to S_A.
- Operator: A = result, go to S_B with B empty.
- Equals: re-execute with A = result and the last op and last B.

S_ERR:
- Only clear is accepted.

Clear (code F), in any state:
- A, B, entry, digit counts, pending op, err and disp_value all return to 0; state goes to S_A.
- In S_EXEC, clear also pulses alu_abort, and any later alu_done is discarded.

Arithmetic:
- Subtraction producing a negative result is reported by the ALU as alu_err.
- Operands never exceed 9999, so 16 bits suffice; the accumulator multiply is *10 via shift-add.

## Timing
Reset values:
- State S_A.
- alu_start, alu_abort, err: 0.
- alu_op: 0.
- alu_a, alu_b: 0.
- disp_entry, disp_value: 0.

Cycle rules:
- key_valid is sampled at posedge clk. State and registers update at that edge; outputs reflect the change in the next cycle.
- alu_start is asserted in the first cycle of S_EXEC, exactly once per entry into S_EXEC. It is never asserted while an operation is outstanding.
- ALU latency is arbitrary, at least 1 cycle after alu_start; alu_done is accepted only in S_EXEC.
- If alu_done and a clear key_valid arrive in the same cycle, clear wins: the result is dropped and alu_abort is not pulsed, since the ALU is already idle.
- If alu_done and a non-clear key arrive in the same cycle, the result is processed and the key is dropped.
- Reset mid-operation: outputs return to their reset values immediately. No abort is issued; the ALU shares rst.

## Structure
- calc_pkg holds:
  - key code constants (KEY_ADD…KEY_CLR);
  - the op encoding;
  - the state enum;
  - MAX_VAL.
- Sub-module bcd_entry: digit accumulator with parallel binary value, packed BCD, digit count, clear and load-zero inputs. It is instantiated once and shared between the A and B entry phases.

## Test plan
- Keys 1,2,+,3,4,= with ALU latency 5 → one alu_start with a=12, b=34, op=0; disp_value=46; state S_RES.
- Keys 9,9,9,9,9 → disp_entry=0x9999; 5th digit ignored; internal A=9999.
- Keys 5,*,4,-,3,= → first exec 5*4; after done A=20, op=sub; second exec 20-3; disp_value=17.
- Keys 7,/,0,= with ALU returning alu_err → err=1; digit keys are ignored; F clears to S_A with err=0.
- Keys 9,9,9,9,*,2,= with ALU result 19998 → S_ERR, err=1.
- Clear pressed 2 cycles after alu_start → alu_abort pulse, state S_A, late alu_done ignored, disp_value stays 0. Repeat with clear coincident with alu_done → no abort, result dropped.
